// File: rtl/shift_issue_pipe_if.sv
// Bundle of the request, external-shifter and result signals of shift_issue_pipe.
//   req_*      : request handshake into the issue FIFO (valid/ready, data, amt, op)
//   sh_*       : operand/amount out to the combinational right shifter, result back in
//   res_*      : registered result handshake plus zero/negative flags
//   occupancy  : current FIFO entry count
// Modport slave is the pipe itself; master is the producer/consumer/shifter side.
interface shift_issue_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [SHW-1:0]   req_amt;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] sh_in;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sh_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_neg;
  logic [SHW-1:0]   occupancy;

  modport slave (
    input  req_valid, req_data, req_amt, req_op, sh_out, res_ready,
    output req_ready, sh_in, sh_amt, res_valid, res_data, res_zero, res_neg, occupancy
  );

  modport master (
    output req_valid, req_data, req_amt, req_op, sh_out, res_ready,
    input  req_ready, sh_in, sh_amt, res_valid, res_data, res_zero, res_neg, occupancy
  );
endinterface

// File: rtl/shift_issue_pipe.sv
// Issue/retire stage around an external combinational logical right shifter.
// Requests are queued in a DEPTH-entry FIFO; the head drives the shifter
// (bit-reversed for SLL so a right shifter can do left shifts), and the
// post-processed result is registered into a single output stage.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : shift_issue_pipe_if.slave (request, shifter, result, occupancy)
module shift_issue_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_issue_pipe_if.slave     bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [1:0]       op;
  } req_t;

  function automatic logic [WIDTH-1:0] brev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_neg_q, res_neg_d;

  logic             empty, ready, push, retire;
  req_t             head;
  logic [WIDTH-1:0] result;

  assign empty  = (cnt_q == '0);
  // No pop credit: a full FIFO refuses even when the head retires this cycle.
  assign ready  = (cnt_q < DEPTH_C);
  assign push   = bus.req_valid && ready;
  assign retire = !empty && (!res_valid_q || bus.res_ready);
  assign head   = mem_q[rptr_q];

  assign bus.sh_in  = empty ? '0 : ((head.op == OP_SLL) ? brev(head.data) : head.data);
  assign bus.sh_amt = empty ? '0 : head.amt;

  // Post-processing of the shifter output for the head request.
  always_comb begin
    result = bus.sh_out;
    if (head.amt == '0)
      result = head.data;
    else if (head.op == OP_SLL)
      result = brev(bus.sh_out);
    else if (head.op == OP_SRA && head.data[WIDTH-1])
      result = bus.sh_out | ~({WIDTH{1'b1}} >> head.amt);
  end

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
    if (push) begin
      mem_d[wptr_q] = '{data: bus.req_data, amt: bus.req_amt, op: bus.req_op};
      wptr_d        = wptr_q + AW'(1);
    end
    if (retire) begin
      rptr_d      = rptr_q + AW'(1);
      res_valid_d = 1'b1;
      res_data_d  = result;
      res_zero_d  = (result == '0);
      res_neg_d   = result[WIDTH-1];
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
    case ({push, retire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
    end
  end

  // Payload storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.req_ready = ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_neg   = res_neg_q;
  assign bus.occupancy = SHW'(cnt_q);
endmodule

// File: doc/shift_issue_pipe.md
Name: shift_issue_pipe

Overview:
Upstream issue/retire stage wrapped around the 32-bit gate-level logical right shifter in the ALU32 datapath. Accepts shift requests through a valid/ready handshake and buffers them in a small FIFO. Presents the head request to the external combinational right shifter, with bit reversal for left shifts. Registers the post-processed result (left-shift unreversal, arithmetic sign fill, flags) into an output stage with its own valid/ready handshake.

Parameters:
WIDTH, 32, datapath width; must equal the shifter width.
SHW, 5, shift-amount width; WIDTH = 2**SHW.
DEPTH, 2, request FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
req_valid  in  1  request present.
req_ready  out  1  FIFO can accept; high when count < DEPTH.
req_data  in  WIDTH  operand.
req_amt  in  SHW  shift amount.
req_op  in  2  00 SRL, 01 SLL, 10 SRA, 11 reserved (executed as SRL).
sh_in  out  WIDTH  operand to external right shifter (In1).
sh_amt  out  SHW  amount to external right shifter (In2).
sh_out  in  WIDTH  external shifter result (Out), combinational from sh_in/sh_amt.
res_valid  out  1  result register holds a valid result.
res_ready  in  1  consumer accepts result.
res_data  out  WIDTH  shift result.
res_zero  out  1  res_data == 0.
res_neg  out  1  res_data[WIDTH-1].
occupancy  out  SHW  current FIFO entry count, 0..DEPTH, zero-extended.

Behaviour:
- Reset (rst_n low at a rising edge): FIFO read/write pointers = 0, count = 0, res_valid = 0, res_data = 0, res_zero = 0, res_neg = 0. In-flight requests are discarded, including those in the FIFO and the output register. req_ready is high on the first cycle after reset release.
- Push: fires when req_valid && req_ready; writes {data, amt, op} at the write pointer. Pointer wraps modulo DEPTH.
- req_ready = (count < DEPTH). There is no same-cycle pop credit: when full, req_ready stays low even if a pop occurs in that cycle.
- Head drive, combinational:
  - FIFO empty: sh_in = 0, sh_amt = 0.
  - Otherwise sh_amt = head amt.
  - sh_in = bit-reverse(head data) for SLL; head data for all other ops.
- Retire: fires when FIFO non-empty && (!res_valid || res_ready). Pops the head and loads the output register.
- Result rules:
  - SRL and op 11: res_data = sh_out.
  - SLL: res_data = bit-reverse(sh_out).
  - SRA: res_data = sh_out | ~({WIDTH{1}} >> amt) when head data[WIDTH-1] = 1; otherwise sh_out.
  - Amount 0 returns the operand unchanged for every op.
  - res_zero and res_neg are registered together with res_data.
- Output handshake:
  - res_valid sets on retire.
  - res_valid clears when res_ready is high and no retire occurs in the same cycle.
  - Retire while res_valid && res_ready replaces the result back-to-back, and res_valid stays high.
  - While res_valid && !res_ready, res_data and the flags hold stable.
- count: increments on push only, decrements on retire only, unchanged on simultaneous push+retire.
- Latency: a request pushed at edge k into an empty FIFO with a free output stage appears with res_valid high after edge k+1. Sustained throughput is one result per cycle.
- Ordering: results retire in strict request order.
- Total capacity: DEPTH + 1 requests in flight (FIFO plus output register).

Test Plan:
- Latency, SRL: push data 0x80000000, amt 4, op 00, res_ready=1 -> after 2 edges res_data=0x08000000, res_neg=0, res_zero=0, occupancy back to 0.
- SLL: push data 0x00000001, amt 31, op 01 -> res_data=0x80000000, res_neg=1. Push data 0x12345678, amt 0 -> res_data=0x12345678.
- SRA: data 0x80000000, amt 4 -> 0xF8000000. Data 0xF0000000, amt 31 -> 0xFFFFFFFF. Data 0x70000000, amt 4 -> 0x07000000. Data 0x00000001, amt 1, op 00 -> 0x00000000, res_zero=1.
- Backpressure: res_ready=0, push A,B,C,D on consecutive cycles:
  - A lands in the output register; B and C fill the FIFO; occupancy=2.
  - req_ready goes low and D is held off.
  - Raise res_ready -> results A,B,C,D emerge in order, one per cycle, with no duplicates or drops.
- Streaming: 64 random requests with res_ready randomly toggling -> output sequence matches a reference model. The output register never changes while stalled.
- Reset mid-operation: with occupancy=2 and res_valid=1, assert rst_n=0 for one edge -> res_valid=0, res_data=0, occupancy=0, req_ready=1. Old requests never reappear.
